// File: rtl/gfx_pkg.sv
// Shared graphics definitions: screen geometry defaults, plotter FSM states
// and the packed pixel record carried through the plotter FIFO.
package gfx_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int COORD_X_W = 10;
  localparam int COORD_Y_W = 9;
  localparam int COLOR_W   = 4;
  localparam int ADDR_W    = 19;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    RETIRE
  } plot_state_t;

  typedef struct packed {
    logic                 last;
    logic [COLOR_W-1:0]   color;
    logic [COORD_Y_W-1:0] y;
    logic [COORD_X_W-1:0] x;
  } pixel_t;

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous FIFO with registered occupancy count; pushes while full
// and pops while empty are ignored.
module pix_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_plotter.sv
// Framebuffer write-back stage: queues incoming pixels, clips them against the
// screen, issues one acknowledged write per visible pixel and flags primitive ends.
module pixel_plotter #(
  parameter int H_RES      = gfx_pkg::H_RES,
  parameter int V_RES      = gfx_pkg::V_RES,
  parameter int FIFO_DEPTH = 4,
  parameter int COLOR_W    = gfx_pkg::COLOR_W,
  parameter int ADDR_W     = gfx_pkg::ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic [gfx_pkg::COORD_X_W-1:0]  pix_x,
  input  logic [gfx_pkg::COORD_Y_W-1:0]  pix_y,
  input  logic [COLOR_W-1:0]             pix_color,
  input  logic                           pix_last,
  output logic                           fb_we,
  output logic [ADDR_W-1:0]              fb_addr,
  output logic [COLOR_W-1:0]             fb_data,
  input  logic                           fb_ack,
  output logic                           prim_done,
  output logic [15:0]                    clip_cnt,
  input  logic                           clr_stats
);

  import gfx_pkg::*;

  localparam int ENTRY_W = 1 + COLOR_W + COORD_Y_W + COORD_X_W;

  plot_state_t          state_q;
  plot_state_t          state_d;
  logic [ENTRY_W-1:0]   fifo_wdata;
  logic [ENTRY_W-1:0]   fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 ready_en;
  logic [COORD_X_W-1:0] cur_x;
  logic [COORD_Y_W-1:0] cur_y;
  logic [COLOR_W-1:0]   cur_color;
  logic                 cur_last;
  logic [ADDR_W-1:0]    lin_addr;
  logic                 clip;
  logic                 clip_evt;

  // ready_en holds pix_ready low until the first clock after reset release.
  assign pix_ready  = ready_en && !fifo_full;
  assign fifo_push  = pix_valid && pix_ready;
  assign fifo_wdata = {pix_last, pix_color, pix_y, pix_x};

  pix_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data (fifo_wdata),
    .pop     (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign lin_addr = ADDR_W'(cur_y) * ADDR_W'(H_RES) + ADDR_W'(cur_x);
  assign clip     = (32'(cur_x) >= H_RES) || (32'(cur_y) >= V_RES);
  assign clip_evt = (state_q == LOAD) && clip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD:  state_d = clip ? RETIRE : WRITE;
      WRITE: if (fb_ack) state_d = RETIRE;
      RETIRE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      cur_x     <= '0;
      cur_y     <= '0;
      cur_color <= '0;
      cur_last  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (fifo_pop) {cur_last, cur_color, cur_y, cur_x} <= fifo_rdata;
    end
  end

  // Write port and prim_done only move on LOAD->WRITE and ->RETIRE transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      prim_done <= 1'b0;
    end else begin
      prim_done <= 1'b0;
      if ((state_q == LOAD) && !clip) begin
        fb_we   <= 1'b1;
        fb_addr <= lin_addr;
        fb_data <= cur_color;
      end
      if ((state_q == WRITE) && fb_ack) fb_we <= 1'b0;
      if (cur_last && (clip_evt || ((state_q == WRITE) && fb_ack))) prim_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              clip_cnt <= '0;
    else if (clr_stats)                      clip_cnt <= '0;
    else if (clip_evt && clip_cnt != '1)     clip_cnt <= clip_cnt + 16'd1;
  end

endmodule

// File: tb/tb_pixel_plotter.sv
// Self-checking bench for pixel_plotter: directed scenarios plus a randomized
// pixel stream, all scored against a coordinate-level model of the plotter.
module tb_pixel_plotter;

  import gfx_pkg::*;

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } wr_t;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [9:0]  pix_x     = '0;
  logic [8:0]  pix_y     = '0;
  logic [3:0]  pix_color = '0;
  logic        pix_last  = 1'b0;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [3:0]  fb_data;
  logic        fb_ack    = 1'b0;
  logic        prim_done;
  logic [15:0] clip_cnt;
  logic        clr_stats = 1'b0;

  int          check_count = 0;
  int          pass_count  = 0;
  int unsigned cyc         = 0;

  wr_t         exp_wr[$];
  wr_t         obs_wr[$];
  int          exp_prim = 0;
  int          obs_prim = 0;
  int unsigned exp_clip = 0;
  int unsigned last_ack_edge = 0;
  int unsigned last_prim_cyc = 0;
  int          ack_delay = 0;
  bit          ack_random = 1'b0;
  bit          backpressure_seen = 1'b0;
  int          hold_err = 0;

  pixel_plotter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .pix_last  (pix_last),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_ack    (fb_ack),
    .prim_done (prim_done),
    .clip_cnt  (clip_cnt),
    .clr_stats (clr_stats)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: acks each write after a fixed or random wait and logs it.
  initial begin
    int waited = 0;
    int target = 0;
    logic [18:0] hold_addr = '0;
    logic [3:0]  hold_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fb_ack = 1'b0;
        waited = 0;
      end else if (fb_ack) begin
        fb_ack = 1'b0;
      end else if (fb_we) begin
        if (waited == 0) begin
          target    = ack_random ? int'($urandom_range(0, 3)) : ack_delay;
          hold_addr = fb_addr;
          hold_data = fb_data;
        end else if (fb_addr != hold_addr || fb_data != hold_data) begin
          hold_err++;
        end
        if (waited >= target) begin
          fb_ack = 1'b1;
          obs_wr.push_back('{int'(fb_addr), int'(fb_data)});
          last_ack_edge = cyc + 1;
          waited = 0;
        end else begin
          waited++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && prim_done) begin
        obs_prim++;
        last_prim_cyc = cyc;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, got, exp);
  endtask

  // Offers one pixel and scores it in the model once the handshake completes.
  task automatic applyStimulus(input int unsigned x, input int unsigned y,
                               input int unsigned c, input bit last);
    int guard = 0;
    pix_valid = 1'b1;
    pix_x     = x[9:0];
    pix_y     = y[8:0];
    pix_color = c[3:0];
    pix_last  = last;
    while (!pix_ready && guard < 2000) begin
      backpressure_seen = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) checkOutput("accept_timeout", 1, 0);
    @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    if (x >= H_RES || y >= V_RES) begin
      if (exp_clip != 16'hFFFF) exp_clip++;
    end else begin
      exp_wr.push_back('{y * H_RES + x, c % 16});
    end
    if (last) exp_prim++;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((obs_wr.size() < exp_wr.size() || obs_prim < exp_prim) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain_timeout", guard >= 3000, 0);
    repeat (20) @(negedge clk);
  endtask

  task automatic clearModel();
    exp_wr.delete();
    obs_wr.delete();
    exp_prim = 0;
    obs_prim = 0;
  endtask

  task automatic compareResults(input string tag);
    int n;
    checkOutput({tag, "_wr_count"}, obs_wr.size(), exp_wr.size());
    n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), obs_wr[i].addr, exp_wr[i].addr);
      checkOutput($sformatf("%s_data%0d", tag, i), obs_wr[i].data, exp_wr[i].data);
    end
    checkOutput({tag, "_prim"}, obs_prim, exp_prim);
    checkOutput({tag, "_clip"}, clip_cnt, exp_clip);
    clearModel();
  endtask

  task automatic clearStats();
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    exp_clip  = 0;
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", pix_ready, 0);
    checkOutput("reset_we", fb_we, 0);
    checkOutput("reset_addr", fb_addr, 0);
    checkOutput("reset_data", fb_data, 0);
    checkOutput("reset_done", prim_done, 0);
    checkOutput("reset_clip", clip_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ready", pix_ready, 1);

    $display("[TB] single pixel");
    ack_delay = 0;
    applyStimulus(10, 40, 5, 1'b1);
    waitDrain();
    checkOutput("single_done_timing", last_prim_cyc, last_ack_edge);
    compareResults("single");

    $display("[TB] 21-pixel stream, ack delay 3");
    ack_delay = 3;
    backpressure_seen = 1'b0;
    for (int x = 10; x <= 30; x++) applyStimulus(x, 40, x % 16, x == 30);
    waitDrain();
    checkOutput("stream_backpressure", backpressure_seen, 1);
    checkOutput("stream_done_timing", last_prim_cyc, last_ack_edge);
    compareResults("stream");

    $display("[TB] clipping");
    ack_delay = 0;
    clearStats();
    applyStimulus(639, 479, 7, 1'b0);
    applyStimulus(640, 0, 3, 1'b0);
    applyStimulus(0, 480, 2, 1'b0);
    waitDrain();
    compareResults("clip");

    applyStimulus(700, 10, 6, 1'b1);
    waitDrain();
    compareResults("clip_last");

    $display("[TB] clip counter edge cases");
    applyStimulus(700, 20, 1, 1'b0);
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    exp_clip  = 0;
    waitDrain();
    compareResults("clr_vs_clip");

    force dut.clip_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.clip_cnt;
    exp_clip = 16'hFFFE;
    applyStimulus(650, 5, 1, 1'b0);
    applyStimulus(5, 500, 1, 1'b0);
    waitDrain();
    compareResults("saturate");
    clearStats();

    $display("[TB] randomized stream");
    ack_random = 1'b1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus($urandom_range(0, 720), $urandom_range(0, 511),
                    $urandom_range(0, 15), $urandom_range(0, 3) == 0);
    end
    waitDrain();
    compareResults("random");
    ack_random = 1'b0;

    $display("[TB] reset during write");
    ack_delay = 100000;
    for (int i = 0; i < 4; i++) applyStimulus(100 + i, 200, 9, i == 3);
    guard = 0;
    while (!fb_we && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rst_write_started", fb_we, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_we_drop", fb_we, 0);
    checkOutput("rst_ready_low", pix_ready, 0);
    checkOutput("rst_done_low", prim_done, 0);
    repeat (2) @(negedge clk);
    clearModel();
    exp_clip  = 0;
    ack_delay = 0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_release_ready", pix_ready, 1);
    repeat (30) @(negedge clk);
    checkOutput("rst_no_stale_writes", obs_wr.size(), 0);
    checkOutput("rst_no_stale_done", obs_prim, 0);
    applyStimulus(1, 1, 9, 1'b1);
    waitDrain();
    compareResults("after_reset");

    checkOutput("fb_hold_stable", hold_err, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
